// File: rtl/sao_clk_pkg.sv
// Shared types and widths for the slow-clock interval receiver.
package sao_clk_pkg;

    localparam int IVL_W    = 3;
    localparam int GOOD_W   = 4;
    localparam int ERRCNT_W = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } sao_state_e;

    function automatic logic [ERRCNT_W-1:0] errcnt_sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == {ERRCNT_W{1'b1}}) ? v : v + ERRCNT_W'(1);
    endfunction

endpackage

// File: rtl/sao_edge_det.sv
// Two-register edge detector for a divided clock that is synchronous to clk.
// The edge flag is registered once more so it lines up with the delayed level.
module sao_edge_det
    import sao_clk_pkg::*;
(
    input  logic clk,
    input  logic arst,
    input  logic clr,
    input  logic sig,
    output logic edge_seen,
    output logic level
);

    logic s_q_r;
    logic s_qq_r;
    logic edge_r;

    // Sample the input twice and register the transition flag
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            s_q_r  <= 1'b0;
            s_qq_r <= 1'b0;
            edge_r <= 1'b0;
        end else if (clr) begin
            s_q_r  <= 1'b0;
            s_qq_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            s_q_r  <= sig;
            s_qq_r <= s_q_r;
            edge_r <= s_q_r ^ s_qq_r;
        end
    end

    assign edge_seen = edge_r;
    assign level     = s_qq_r;

endmodule

// File: rtl/sao_clk_slow_rx.sv
// Tracks a divided clock sampled as data, locks on MULT-cycle half-periods and emits edge strobes.
// Define SAO_CLK_RX_ERRCNT_EN to build the saturating loss-of-lock counter on err_cnt.
module sao_clk_slow_rx
    import sao_clk_pkg::*;
#(
    parameter int MULT     = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       clr,
    input  logic       clk_slow_in,
    output logic       locked,
    output logic [2:0] phase,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic       err,
    output logic [7:0] err_cnt
);

    // ivl carries one spare bit so it can saturate at MULT=8
    localparam logic [IVL_W:0]    IVL_SAT    = (IVL_W+1)'(MULT);
    localparam logic [IVL_W:0]    IVL_GOOD   = (IVL_W+1)'(MULT - 1);
    localparam logic [IVL_W:0]    IVL_ZERO   = (IVL_W+1)'(0);
    localparam logic [IVL_W:0]    IVL_ONE    = (IVL_W+1)'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_ZERO  = GOOD_W'(0);
    localparam logic [GOOD_W-1:0] GOOD_ONE   = GOOD_W'(1);
    localparam logic [IVL_W-1:0]  PHASE_ZERO = IVL_W'(0);

    logic              edge_s;
    logic              level_s;
    logic [IVL_W:0]    ivl_next_s;
    logic              good_s;
    logic              timeout_s;

    sao_state_e        state_r;
    logic [IVL_W:0]    ivl_r;
    logic [GOOD_W-1:0] good_cnt_r;
    logic              locked_r;
    logic [IVL_W-1:0]  phase_r;
    logic              rise_r;
    logic              fall_r;
    logic              err_r;

    sao_edge_det u_edge (
        .clk       (clk),
        .arst      (arst),
        .clr       (clr),
        .sig       (clk_slow_in),
        .edge_seen (edge_s),
        .level     (level_s)
    );

    // Next interval count and edge classification
    always_comb begin
        ivl_next_s = ivl_r;
        good_s     = 1'b0;
        timeout_s  = 1'b0;
        if (edge_s) begin
            ivl_next_s = IVL_ZERO;
            good_s     = (ivl_r == IVL_GOOD);
        end else if (ivl_r == IVL_SAT) begin
            ivl_next_s = ivl_r;
        end else begin
            ivl_next_s = ivl_r + IVL_ONE;
            timeout_s  = (ivl_r == IVL_GOOD);
        end
    end

    // Lock FSM with registered outputs; clr behaves exactly like arst
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r    <= SEARCH;
            ivl_r      <= IVL_ZERO;
            good_cnt_r <= GOOD_ZERO;
            locked_r   <= 1'b0;
            phase_r    <= PHASE_ZERO;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            err_r      <= 1'b0;
        end else if (clr) begin
            state_r    <= SEARCH;
            ivl_r      <= IVL_ZERO;
            good_cnt_r <= GOOD_ZERO;
            locked_r   <= 1'b0;
            phase_r    <= PHASE_ZERO;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            ivl_r  <= ivl_next_s;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                SEARCH: begin
                    locked_r <= 1'b0;
                    phase_r  <= PHASE_ZERO;
                    if (edge_s) begin
                        state_r    <= ACQUIRE;
                        good_cnt_r <= GOOD_ZERO;
                    end else begin
                        state_r <= SEARCH;
                    end
                end
                ACQUIRE: begin
                    locked_r <= 1'b0;
                    phase_r  <= PHASE_ZERO;
                    if (good_s && (good_cnt_r == GOOD_LAST)) begin
                        state_r    <= LOCKED;
                        good_cnt_r <= good_cnt_r + GOOD_ONE;
                        locked_r   <= 1'b1;
                        phase_r    <= ivl_next_s[IVL_W-1:0];
                        rise_r     <= level_s;
                        fall_r     <= ~level_s;
                    end else if (good_s) begin
                        good_cnt_r <= good_cnt_r + GOOD_ONE;
                    end else if (edge_s) begin
                        good_cnt_r <= GOOD_ZERO;
                    end else if (timeout_s) begin
                        state_r <= SEARCH;
                    end else begin
                        state_r <= ACQUIRE;
                    end
                end
                LOCKED: begin
                    if (good_s) begin
                        locked_r <= 1'b1;
                        phase_r  <= ivl_next_s[IVL_W-1:0];
                        rise_r   <= level_s;
                        fall_r   <= ~level_s;
                    end else if (edge_s) begin
                        state_r    <= ACQUIRE;
                        good_cnt_r <= GOOD_ZERO;
                        locked_r   <= 1'b0;
                        phase_r    <= PHASE_ZERO;
                        err_r      <= 1'b1;
                    end else if (timeout_s) begin
                        state_r  <= SEARCH;
                        locked_r <= 1'b0;
                        phase_r  <= PHASE_ZERO;
                        err_r    <= 1'b1;
                    end else begin
                        locked_r <= 1'b1;
                        phase_r  <= ivl_next_s[IVL_W-1:0];
                    end
                end
                default: begin
                    state_r    <= SEARCH;
                    good_cnt_r <= GOOD_ZERO;
                    locked_r   <= 1'b0;
                    phase_r    <= PHASE_ZERO;
                end
            endcase
        end
    end

`ifdef SAO_CLK_RX_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_r;

    // Saturating count of loss-of-lock pulses
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            err_cnt_r <= ERRCNT_W'(0);
        end else if (clr) begin
            err_cnt_r <= ERRCNT_W'(0);
        end else if (err_r) begin
            err_cnt_r <= errcnt_sat_inc(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'd0;
`endif

    assign locked   = locked_r;
    assign phase    = phase_r;
    assign rise_stb = rise_r;
    assign fall_stb = fall_r;
    assign err      = err_r;

endmodule

// File: tb/tb_sao_clk_slow_rx.sv
// Scoreboard bench for sao_clk_slow_rx: directed toggle patterns, expected strobes/errors queued, monitor compares.
module tb_sao_clk_slow_rx;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    logic clr  = 1'b0;
    logic cs   = 1'b0;
    logic cs2  = 1'b0;
    logic cs8  = 1'b0;
    logic sel8 = 1'b0;

    logic       locked, rise_stb, fall_stb, err;
    logic [2:0] phase;
    logic [7:0] err_cnt;
    logic       lk2, r2, f2, e2, lk8, r8, f8, e8;
    logic [2:0] ph2, ph8;
    logic [7:0] ec2, ec8;
    logic       sw_locked, sw_fall, sw_err;
    logic [2:0] sw_phase;

    always #5 clk = ~clk;

    sao_clk_slow_rx #(.MULT(3), .LOCK_CNT(4)) u_dut (
        .clk(clk), .arst(arst), .clr(clr), .clk_slow_in(cs), .locked(locked), .phase(phase),
        .rise_stb(rise_stb), .fall_stb(fall_stb), .err(err), .err_cnt(err_cnt));
    sao_clk_slow_rx #(.MULT(2), .LOCK_CNT(1)) u_m2 (
        .clk(clk), .arst(arst), .clr(clr), .clk_slow_in(cs2), .locked(lk2), .phase(ph2),
        .rise_stb(r2), .fall_stb(f2), .err(e2), .err_cnt(ec2));
    sao_clk_slow_rx #(.MULT(8), .LOCK_CNT(1)) u_m8 (
        .clk(clk), .arst(arst), .clr(clr), .clk_slow_in(cs8), .locked(lk8), .phase(ph8),
        .rise_stb(r8), .fall_stb(f8), .err(e8), .err_cnt(ec8));

    assign sw_locked = sel8 ? lk8 : lk2;
    assign sw_fall   = sel8 ? f8  : f2;
    assign sw_err    = sel8 ? e8  : e2;
    assign sw_phase  = sel8 ? ph8 : ph2;

    typedef struct { logic [2:0] kind; logic lck; int gap; } ev_t;
    ev_t q[$];

    localparam int EV_NONE = 0;
    localparam int EV_STB  = 1;
    localparam int EV_ERR  = 2;

    int n_chk = 0, n_fail = 0, cyc = 0, last_evt = 0, exp_ph = 0, exp_errs = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_errcnt();
`ifdef SAO_CLK_RX_ERRCNT_EN
        return (exp_errs > 255) ? 255 : exp_errs;
`else
        return 0;
`endif
    endfunction

    // Monitor: pop and compare on every strobe/err, track phase while locked
    always @(negedge clk) begin : mon
        ev_t e;
        cyc++;
        if (mon_en && !arst) begin
            if (rise_stb || fall_stb || err) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", 32'({err, fall_stb, rise_stb}), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", 32'({err, fall_stb, rise_stb}), 32'(e.kind));
                    chk("event_locked", 32'(locked), 32'(e.lck));
                    if (e.gap != 0) chk("event_gap", 32'(cyc - last_evt), 32'(e.gap));
                end
                last_evt = cyc;
            end
            if (locked) begin
                if (rise_stb || fall_stb) begin
                    chk("phase_at_strobe", 32'(phase), 32'd0);
                    exp_ph = 1;
                end else begin
                    chk("phase_run", 32'(phase), 32'(exp_ph));
                    exp_ph++;
                end
            end else begin
                chk("phase_unlocked", 32'(phase), 32'd0);
            end
`ifndef SAO_CLK_RX_ERRCNT_EN
            chk("errcnt_zero", 32'(err_cnt), 32'd0);
`endif
        end
    end

    // Wait n cycles, queue the expected response of the coming edge, then toggle
    task automatic edge_after(input int n, input int ev, input int gap);
        ev_t e;
        repeat (n) @(posedge clk);
        #1;
        if (ev == EV_STB) begin
            e.kind = cs ? 3'b010 : 3'b001;
            e.lck  = 1'b1;
            e.gap  = gap;
            q.push_back(e);
        end else if (ev == EV_ERR) begin
            e.kind = 3'b100;
            e.lck  = 1'b0;
            e.gap  = gap;
            q.push_back(e);
            exp_errs++;
        end
        cs = ~cs;
    endtask

    task automatic push_timeout();
        ev_t e;
        e.kind = 3'b100;
        e.lck  = 1'b0;
        e.gap  = 3;
        q.push_back(e);
        exp_errs++;
    endtask

    task automatic lock_seq();
        repeat (4) edge_after(3, EV_NONE, 0);
        edge_after(3, EV_STB, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_rise"}, 32'(rise_stb), 32'd0);
        chk({tag, "_fall"}, 32'(fall_stb), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_errcnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic sweep(input int m, input bit s);
        int first_lk = -1;
        int first_fall = 0;
        int mx = 0;
        int n_err = 0;
        sel8 = s;
        for (int c = 0; c < m * 8 + 12; c++) begin
            @(posedge clk);
            #1;
            if (c < m * 8 && (c % m) == 0) begin
                if (s) cs8 = ~cs8;
                else   cs2 = ~cs2;
            end
            @(negedge clk);
            if (sw_locked && first_lk < 0) begin
                first_lk   = c;
                first_fall = int'(sw_fall);
            end
            if (sw_locked && int'(sw_phase) > mx) mx = int'(sw_phase);
            if (sw_err) n_err++;
        end
        chk($sformatf("sweep%0d_lock_cycle", m), 32'(first_lk), 32'(m + 3));
        chk($sformatf("sweep%0d_lock_strobe_fall", m), 32'(first_fall), 32'd1);
        chk($sformatf("sweep%0d_phase_max", m), 32'(mx), 32'(m - 1));
        chk($sformatf("sweep%0d_timeout_err", m), 32'(n_err), 32'd1);
    endtask

    initial begin
        #1 arst = 1'b1;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        mon_en = 1'b1;

        // Nominal lock: edge 1 unjudged, edges 2..4 good, edge 5 locks
        edge_after(2, EV_NONE, 0);
        repeat (3) edge_after(3, EV_NONE, 0);
        edge_after(3, EV_STB, 0);
        repeat (5) edge_after(3, EV_STB, 3);
        @(negedge clk);
        chk("nominal_locked", 32'(locked), 32'd1);

        // Short half-period, then four good edges to relock
        edge_after(2, EV_ERR, 2);
        repeat (3) edge_after(3, EV_NONE, 0);
        edge_after(3, EV_STB, 0);
        edge_after(3, EV_STB, 3);

        // Stuck input: timeout error three cycles after the last strobe
        push_timeout();
        repeat (8) @(negedge clk);
        chk("stuck_locked", 32'(locked), 32'd0);
        chk("stuck_phase", 32'(phase), 32'd0);
        chk("stuck_queue_empty", 32'(q.size()), 32'd0);
        chk("errcnt_after_losses", 32'(err_cnt), 32'(exp_errcnt()));

        // Asynchronous reset while locked
        lock_seq();
        edge_after(3, EV_STB, 3);
        repeat (4) @(negedge clk);
        chk("pre_arst_locked", 32'(locked), 32'd1);
        #1 arst = 1'b1;
        exp_errs = 0;
        #1 chk_all_zero("arst_mid");
        @(posedge clk);
        #1 arst = 1'b0;

        // clr coinciding with an edge: edge discarded, no strobe
        lock_seq();
        edge_after(3, EV_STB, 3);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        cs  = ~cs;
        exp_errs = 0;
        @(posedge clk);
        #1 clr = 1'b0;
        repeat (12) @(negedge clk);
        chk("clr_locked", 32'(locked), 32'd0);
        chk("clr_queue_empty", 32'(q.size()), 32'd0);
        chk("clr_errcnt", 32'(err_cnt), 32'd0);

`ifdef SAO_CLK_RX_ERRCNT_EN
        lock_seq();
        for (int i = 0; i < 300; i++) begin
            edge_after(2, EV_ERR, 2);
            repeat (3) edge_after(3, EV_NONE, 0);
            edge_after(3, EV_STB, 0);
        end
        push_timeout();
        repeat (10) @(negedge clk);
        chk("errcnt_saturated", 32'(err_cnt), 32'd255);
`endif

        sweep(2, 1'b0);
        sweep(8, 1'b1);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_errcnt", 32'(err_cnt), 32'(exp_errcnt()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
